// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: round-robin scheduler for the single read port of a
// pseudo-dual-port RAM. A granted client gets one burst of consecutive reads.
// The returned words are tagged with the owner index and a last-word flag,
// and are aligned to the RAM's one-cycle registered read latency.
module ram_read_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int REQUESTERS    = 4,
  parameter int LENGTH_WIDTH  = 8
) (
  input  logic                               ClockRead,
  input  logic                               Reset,
  input  logic [REQUESTERS-1:0]              Request_i,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] Address_i,
  input  logic [REQUESTERS*LENGTH_WIDTH-1:0] Length_i,
  output logic [REQUESTERS-1:0]              Grant_o,
  output logic                               Busy_o,
  output logic                               RamReadEnable_o,
  output logic [ADDRESS_WIDTH-1:0]           RamAddress_o,
  input  logic [DATA_WIDTH-1:0]              RamData_i,
  output logic [DATA_WIDTH-1:0]              Data_o,
  output logic                               Valid_o,
  output logic [$clog2(REQUESTERS)-1:0]      Owner_o,
  output logic                               Last_o
);

  localparam int          OWNER_WIDTH = $clog2(REQUESTERS);
  localparam int unsigned REQ_U       = REQUESTERS;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [LENGTH_WIDTH:0] ONE = {{LENGTH_WIDTH{1'b0}}, 1'b1};

  logic [0:0]               state;
  logic [OWNER_WIDTH-1:0]   pointer;
  logic [OWNER_WIDTH-1:0]   owner;
  logic [LENGTH_WIDTH:0]    remaining;

  logic                     found;
  logic [OWNER_WIDTH-1:0]   pick;
  logic [OWNER_WIDTH-1:0]   pointer_next;
  logic [REQUESTERS-1:0]    grant_onehot;
  logic [ADDRESS_WIDTH-1:0] start_address;
  logic [LENGTH_WIDTH-1:0]  start_length;
  logic [LENGTH_WIDTH:0]    burst_length;
  int unsigned              scan_index;
  int unsigned              next_index;

  assign Data_o = RamData_i;
  assign Busy_o = (state == BURST);

  // Round-robin pick: first requesting client at or above the pointer, wrapping.
  always_comb begin
    found        = 1'b0;
    pick         = '0;
    scan_index   = 0;
    next_index   = 0;
    pointer_next = '0;
    grant_onehot = '0;
    for (int unsigned i = 0; i < REQ_U; i++) begin
      scan_index = (32'(pointer) + i) % REQ_U;
      if (!found && Request_i[scan_index[OWNER_WIDTH-1:0]]) begin
        found = 1'b1;
        pick  = scan_index[OWNER_WIDTH-1:0];
      end
    end
    next_index         = (32'(pick) + 1) % REQ_U;
    pointer_next       = next_index[OWNER_WIDTH-1:0];
    grant_onehot[pick] = 1'b1;
  end

  // Burst parameters of the picked client; a zero length means the full range.
  always_comb begin
    start_address = Address_i[pick*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    start_length  = Length_i[pick*LENGTH_WIDTH +: LENGTH_WIDTH];
    burst_length  = {(start_length == '0), start_length};
  end

  // Arbitration/burst sequencing plus the one-cycle-delayed return tags.
  always_ff @(posedge ClockRead or negedge Reset) begin
    if (!Reset) begin
      state           <= IDLE;
      pointer         <= '0;
      owner           <= '0;
      remaining       <= '0;
      Grant_o         <= '0;
      RamReadEnable_o <= 1'b0;
      RamAddress_o    <= '0;
      Valid_o         <= 1'b0;
      Owner_o         <= '0;
      Last_o          <= 1'b0;
    end else begin
      Grant_o <= '0;
      Valid_o <= RamReadEnable_o;
      Owner_o <= owner;
      Last_o  <= RamReadEnable_o && (remaining == ONE);
      case (state)
        IDLE: begin
          if (found) begin
            Grant_o         <= grant_onehot;
            owner           <= pick;
            pointer         <= pointer_next;
            RamAddress_o    <= start_address;
            RamReadEnable_o <= 1'b1;
            remaining       <= burst_length;
            state           <= BURST;
          end
        end
        BURST: begin
          remaining <= remaining - ONE;
          if (remaining > ONE) begin
            RamAddress_o <= RamAddress_o + ADDRESS_WIDTH'(1);
          end else begin
            RamReadEnable_o <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Bench for ram_read_arbiter: behavioural RAM, transaction-level round-robin
// model, and cycle-exact checks of grant, burst addresses and returned words.
module tb_ram_read_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int R  = 4;
  localparam int LW = 8;
  localparam int OW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [R-1:0]    req = '0;
  logic [R*AW-1:0] addr = '0;
  logic [R*LW-1:0] len = '0;
  logic [R-1:0]    grant;
  logic            busy;
  logic            ram_en;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_q = '0;
  logic [DW-1:0]   data;
  logic            valid;
  logic [OW-1:0]   owner;
  logic            last;

  ram_read_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .REQUESTERS(R),
    .LENGTH_WIDTH(LW)
  ) dut (
    .ClockRead(clk),
    .Reset(rst_n),
    .Request_i(req),
    .Address_i(addr),
    .Length_i(len),
    .Grant_o(grant),
    .Busy_o(busy),
    .RamReadEnable_o(ram_en),
    .RamAddress_o(ram_addr),
    .RamData_i(ram_q),
    .Data_o(data),
    .Valid_o(valid),
    .Owner_o(owner),
    .Last_o(last)
  );

  always #5 clk = ~clk;

  // Behavioural RAM read port: registered, one-cycle latency.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) if (ram_en) ram_q <= mem[ram_addr];

  int          tests = 0;
  int          fails = 0;
  int unsigned ptr_m = 0;
  logic [AW-1:0] addr_m [R];
  int unsigned   len_m  [R];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned rr_pick(input logic [R-1:0] m, input int unsigned p);
    for (int i = 0; i < R; i++) if (m[(p + i) % R]) return (p + i) % R;
    return 0;
  endfunction

  task automatic post(input int unsigned k, input logic [AW-1:0] a, input int unsigned l);
    addr[k*AW +: AW] = a;
    len[k*LW +: LW]  = l[LW-1:0];
    addr_m[k] = a;
    len_m[k]  = (l[LW-1:0] == 0) ? (1 << LW) : l;
    req[k]    = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_en"}, ram_en, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_last"}, last, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset");
    ptr_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Serve the burst the model says wins next; caller ensures a request is held.
  task automatic serve(output int unsigned k);
    int unsigned   L;
    logic [AW-1:0] a;
    logic [AW-1:0] t;
    k = rr_pick(req, ptr_m);
    L = len_m[k];
    a = addr_m[k];
    @(posedge clk); #1;
    check("grant", grant, 1 << k);
    check("grant_busy", busy, 1);
    check("grant_en", ram_en, 1);
    check("grant_addr", ram_addr, a);
    check("bubble_valid", valid, 0);
    req[k] = 1'b0;
    ptr_m  = (k + 1) % R;
    for (int j = 1; j <= L; j++) begin
      @(posedge clk); #1;
      check("grant_pulse", grant, 0);
      if (j < L) begin
        t = a + AW'(j);
        check("burst_en", ram_en, 1);
        check("burst_addr", ram_addr, t);
        check("burst_busy", busy, 1);
      end else begin
        check("end_en", ram_en, 0);
        check("end_busy", busy, 0);
      end
      t = a + AW'(j - 1);
      check("valid", valid, 1);
      check("data", data, mem[t]);
      check("owner", owner, k);
      check("last", last, (j == L) ? 1 : 0);
    end
  endtask

  initial begin
    int unsigned k;
    for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
    mem[16'h0010] = 8'hA0;
    mem[16'h0011] = 8'hA1;
    mem[16'h0012] = 8'hA2;

    #1;
    do_reset();

    // Single client 1, three words from 0x0010.
    post(1, 16'h0010, 3);
    serve(k);
    check("t1_winner", k, 1);

    // Clients 0 and 2 together after reset: 0 first, then 2 after the bubble.
    do_reset();
    post(0, 16'h0100, 2);
    post(2, 16'h0200, 2);
    serve(k);
    serve(k);

    // All four continuously requesting single words: strict rotation.
    do_reset();
    for (int c = 0; c < R; c++) post(c, AW'($urandom), 1);
    for (int n = 0; n < 8; n++) begin
      serve(k);
      check("rotation", k, n % R);
      post(k, AW'($urandom), 1);
    end
    for (int n = 0; n < R; n++) serve(k);

    // Length 0 means the full 256-word burst.
    post(3, 16'h0000, 0);
    serve(k);

    // Address wraps at the top of the space.
    post(0, 16'hFFFE, 4);
    serve(k);

    // Reset during the second cycle of an 8-word burst.
    do_reset();
    post(1, 16'h1234, 8);
    @(posedge clk); #1;
    check("mid_grant", grant, 4'b0010);
    req[1] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(posedge clk); #1;
    check_reset_outputs("held");
    rst_n = 1'b1;
    ptr_m = 0;
    post(2, 16'h4321, 3);
    post(0, 16'h0500, 2);
    serve(k);
    check("restart_first", k, 0);
    serve(k);
    check("restart_second", k, 2);

    // Randomised traffic against the round-robin model.
    for (int it = 0; it < 30; it++) begin
      for (int c = 0; c < R; c++)
        if (!req[c] && ($urandom_range(1, 0) == 1)) post(c, AW'($urandom), $urandom_range(7, 1));
      if (req == '0) post($urandom_range(R - 1, 0), AW'($urandom), $urandom_range(7, 1));
      serve(k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
